memory_reader: RTL and testbench
================================

# memory_reader

Read-side controller for the dual-port block RAM. On a start pulse it reads a burst of `nent` words from port b, beginning at a base address. It absorbs the RAM read latency and presents the words as a valid/ready stream with a last flag. It sits between the RAM's port b (`addrb`/`enb`/`regceb`/`doutb`) and the downstream event formatter, and takes its burst length from the RAM's `nent_0` entry count.

## Interface

**Parameters**
- `RAM_WIDTH`, 18: data width; must match the RAM.
- `RAM_DEPTH`, 1024: RAM entries.
  - Address width `AW` = clogb2(`RAM_DEPTH`).
- `RAM_PERFORMANCE`, "HIGH_PERFORMANCE": selects the RAM read latency `L`.
  - "HIGH_PERFORMANCE" gives `L` = 2; "LOW_LATENCY" gives `L` = 1.
  - Must match the RAM instance.
- `FIFO_DEPTH`, 4: output skid FIFO entries; must be ≥ `L`+2.

**Ports**
- `clkb` in 1: the single clock. It drives the RAM read port and all logic here.
- `rstb` in 1: asynchronous, active-high reset.
- `start` in 1: one-cycle request to begin a burst. Sampled only in IDLE.
- `base_addr` in `AW`: first read address. Sampled with `start`.
- `nent` in 5: number of words to read, 0–31. Sampled with `start`.
- `busy` out 1: high from the cycle after an accepted `start` until `done`.
- `done` out 1: one-cycle pulse when the burst completes.
- `addrb` out `AW`: RAM read address.
- `enb` out 1: RAM read enable.
- `regceb` out 1: RAM output register enable. Unused when `L` = 1; held 0 in that case.
- `doutb` in `RAM_WIDTH`: RAM read data.
- `m_data` out `RAM_WIDTH`: stream data.
- `m_valid` out 1: stream valid.
- `m_ready` in 1: stream ready.
- `m_last` out 1: marks the final word of the burst. Qualified by `m_valid`.

## Operation

**State machine** (states IDLE, READ, DRAIN, FIN)
- IDLE
  - On `start` with `nent` ≠ 0: latch `base_addr` into the address counter and `nent` into `remain`, then go to READ.
  - On `start` with `nent` = 0: go to FIN directly. No RAM access, no stream output.
- READ
  - Issue one read per cycle (`enb` = 1, `addrb` = counter) when `inflight` + `fifo_count` < `FIFO_DEPTH`.
  - On each issue: counter + 1 modulo `RAM_DEPTH` (wraps from `RAM_DEPTH`-1 to 0), and `remain` − 1.
  - After the last issue, go to DRAIN.
- DRAIN
  - Stay until the last word is handshaken (`m_valid` & `m_ready` & `m_last`), then go to FIN.
- FIN
  - `done` = 1 for one cycle, `busy` = 0, return to IDLE.
  - A `start` arriving in FIN is ignored.

**Read pipeline**
- The issue strobe feeds an `L`-stage valid shift register.
- `regceb` = stage-1 valid (only when `L` = 2).
- When stage `L` is valid, `doutb` is written into the FIFO that same cycle.
- `inflight` = count of valid stages, 0..`L`.
- The credit check guarantees the FIFO never overflows. An overflow is an assertion failure in the bench.

**FIFO and stream**
- The FIFO output drives `m_data`/`m_valid` directly.
- Pop on `m_valid` & `m_ready`. Push and pop may occur in the same cycle; the count is then unchanged.
- `m_last` is set on the word whose issue had `remain` = 1. It is stored in the FIFO alongside the data.
- `m_data` must hold stable while `m_valid` & !`m_ready`.

**Other rules**
- `start` while `busy` is ignored; no queuing.
- Reset at any time, including mid-burst: return to IDLE and flush the FIFO and pipeline. No `done` is generated for the aborted burst. RAM contents are unaffected.
- Reset values: `busy`, `done`, `enb`, `regceb`, `m_valid`, `m_last` = 0; `addrb`, `m_data` = 0.

## Timing

- `start` sampled in cycle 0. `busy` and the first `enb` (`addrb` = base) are in cycle 1.
- First `m_valid` in cycle `L`+2: cycle 4 for "HIGH_PERFORMANCE", cycle 3 for "LOW_LATENCY".
- With `m_ready` held 1, there is one `enb` and one word per cycle with no bubbles.
  - An N-word burst has its last handshake in cycle `L`+N+1 and `done` in cycle `L`+N+2.
- `nent` = 0: `done` in cycle 1, `busy` never asserts.
- Backpressure: `m_ready` = 0 stalls issue within one cycle once credits are exhausted. `enb` never asserts with zero credits.
- No combinational path from `m_ready` to `m_valid`. The path from `m_ready` to `enb` is allowed.

## Test plan

- **Basic burst.** RAM preloaded with addr+0x100, `L`=2, `base_addr`=5, `nent`=4, `m_ready`=1.
  - Required: `m_data` 0x105..0x108 in cycles 4–7, `m_last` in cycle 7, `done` in cycle 8.
- **Wrap-around.** `RAM_DEPTH`=1024, `base_addr`=1022, `nent`=4.
  - Required: reads at addresses 1022, 1023, 0, 1; data order matches.
- **Zero-length burst.** `nent`=0.
  - Required: `done` in cycle 1; `enb` and `m_valid` never assert; `busy` stays 0.
- **Backpressure.** `nent`=31 with random `m_ready` (50%).
  - Required: all 31 words in order, exactly one `m_last`, no FIFO overflow, `m_data` stable while stalled.
- **Ignored start and LOW_LATENCY.** Pulse `start` mid-burst; separately run `L`=1 with `base_addr`=0, `nent`=2.
  - Required: the mid-burst `start` is ignored. In the `L`=1 run, first `m_valid` is in cycle 3 and `regceb` stays 0.
- **Reset mid-burst.** Assert `rstb` during DRAIN with 2 words in the FIFO.
  - Required: all outputs 0 immediately (asynchronously), no `done` pulse.
  - A subsequent burst with `base_addr`=0, `nent`=1 returns BRAM[0] correctly.

Source files
------------

// File: rtl/memory_reader.sv
// Burst reader for BRAM port b: issues credit-limited reads, absorbs the RAM read latency
// and re-times the returning words through a small skid FIFO onto a valid/ready stream.
module memory_reader #(
    parameter int    RAM_WIDTH       = 18,
    parameter int    RAM_DEPTH       = 1024,
    parameter string RAM_PERFORMANCE = "HIGH_PERFORMANCE",
    parameter int    FIFO_DEPTH      = 4,
    localparam int   AW              = $clog2(RAM_DEPTH)
) (
    input  logic                 clkb,
    input  logic                 rstb,
    input  logic                 start,
    input  logic [AW-1:0]        base_addr,
    input  logic [4:0]           nent,
    output logic                 busy,
    output logic                 done,
    output logic [AW-1:0]        addrb,
    output logic                 enb,
    output logic                 regceb,
    input  logic [RAM_WIDTH-1:0] doutb,
    output logic [RAM_WIDTH-1:0] m_data,
    output logic                 m_valid,
    input  logic                 m_ready,
    output logic                 m_last
);

    localparam int L  = (RAM_PERFORMANCE == "LOW_LATENCY") ? 1 : 2;
    localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = $clog2(FIFO_DEPTH + 1);

    typedef enum logic [1:0] {StIdle, StRead, StDrain, StFin} state_e;

    state_e          state_q, state_d;
    logic [AW-1:0]   addr_q, addr_d;
    logic [4:0]      remain_q, remain_d;
    logic [1:0]      vld_q, vld_d;
    logic [1:0]      lst_q, lst_d;
    logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]   cnt_q, cnt_d;

    logic [RAM_WIDTH-1:0] fifo_data_q [FIFO_DEPTH];
    logic [FIFO_DEPTH-1:0] fifo_last_q;

    logic       issue;
    logic       credit;
    logic       push;
    logic       push_last;
    logic       pop;
    logic [1:0] inflight;

    // Every word in flight already owns a FIFO slot, so the FIFO can never overflow.
    always_comb begin
        inflight = {1'b0, vld_q[0]} + {1'b0, vld_q[1]};
        credit   = (int'(inflight) + int'(cnt_q)) < FIFO_DEPTH;
        issue    = (state_q == StRead) && credit;
        push      = vld_q[L-1];
        push_last = lst_q[L-1];
        m_valid  = (cnt_q != '0);
        pop      = m_valid && m_ready;
        m_data   = m_valid ? fifo_data_q[rd_ptr_q] : '0;
        m_last   = m_valid && fifo_last_q[rd_ptr_q];
        enb      = issue;
        addrb    = addr_q;
        regceb   = (L == 2) ? vld_q[0] : 1'b0;
    end

    always_comb begin
        vld_d[0] = issue;
        vld_d[1] = (L == 2) ? vld_q[0] : 1'b0;
        lst_d[0] = issue && (remain_q == 5'd1);
        lst_d[1] = (L == 2) ? lst_q[0] : 1'b0;
    end

    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        remain_d = remain_q;
        busy     = 1'b0;
        done     = 1'b0;
        case (state_q)
            StIdle: begin
                if (start) begin
                    if (nent != 5'd0) begin
                        addr_d   = base_addr;
                        remain_d = nent;
                        state_d  = StRead;
                    end else begin
                        state_d = StFin;
                    end
                end
            end
            StRead: begin
                busy = 1'b1;
                if (issue) begin
                    addr_d   = (addr_q == AW'(RAM_DEPTH - 1)) ? '0 : addr_q + 1'b1;
                    remain_d = remain_q - 5'd1;
                    if (remain_q == 5'd1) begin
                        state_d = StDrain;
                    end
                end
            end
            StDrain: begin
                busy = 1'b1;
                if (pop && m_last) begin
                    state_d = StFin;
                end
            end
            StFin: begin
                done    = 1'b1;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        if (push) begin
            wr_ptr_d = (wr_ptr_q == PW'(FIFO_DEPTH - 1)) ? '0 : wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d = (rd_ptr_q == PW'(FIFO_DEPTH - 1)) ? '0 : rd_ptr_q + 1'b1;
        end
        if (push && !pop) begin
            cnt_d = cnt_q + 1'b1;
        end else if (!push && pop) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clkb or posedge rstb) begin
        if (rstb) begin
            state_q  <= StIdle;
            addr_q   <= '0;
            remain_q <= '0;
            vld_q    <= '0;
            lst_q    <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            remain_q <= remain_d;
            vld_q    <= vld_d;
            lst_q    <= lst_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    // Storage needs no reset: the outputs are masked while the FIFO is empty.
    always_ff @(posedge clkb) begin
        if (push) begin
            fifo_data_q[wr_ptr_q] <= doutb;
            fifo_last_q[wr_ptr_q] <= push_last;
        end
    end

endmodule

// File: tb/tb_memory_reader.sv
// Runs a HIGH_PERFORMANCE and a LOW_LATENCY reader side by side, each on its own RAM model,
// and checks every burst against addresses, data and cycle timing derived from the burst rules.
module tb_memory_reader;

    localparam int W     = 18;
    localparam int DEPTH = 1024;
    localparam int FD    = 4;

    logic clk = 1'b0;
    logic rst;
    logic start;
    logic [9:0] base_addr;
    logic [4:0] nent;
    logic m_ready;

    logic busy_h, done_h, enb_h, regceb_h, mvalid_h, mlast_h;
    logic [9:0] addrb_h;
    logic [W-1:0] dout_h, lat_h, mdata_h;
    logic busy_l, done_l, enb_l, regceb_l, mvalid_l, mlast_l;
    logic [9:0] addrb_l;
    logic [W-1:0] dout_l, mdata_l;

    logic [W-1:0] mem [DEPTH];

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    memory_reader #(
        .RAM_WIDTH(W), .RAM_DEPTH(DEPTH), .RAM_PERFORMANCE("HIGH_PERFORMANCE"), .FIFO_DEPTH(FD)
    ) dut_h (
        .clkb(clk), .rstb(rst), .start(start), .base_addr(base_addr), .nent(nent),
        .busy(busy_h), .done(done_h), .addrb(addrb_h), .enb(enb_h), .regceb(regceb_h),
        .doutb(dout_h), .m_data(mdata_h), .m_valid(mvalid_h), .m_ready(m_ready),
        .m_last(mlast_h)
    );

    memory_reader #(
        .RAM_WIDTH(W), .RAM_DEPTH(DEPTH), .RAM_PERFORMANCE("LOW_LATENCY"), .FIFO_DEPTH(FD)
    ) dut_l (
        .clkb(clk), .rstb(rst), .start(start), .base_addr(base_addr), .nent(nent),
        .busy(busy_l), .done(done_l), .addrb(addrb_l), .enb(enb_l), .regceb(regceb_l),
        .doutb(dout_l), .m_data(mdata_l), .m_valid(mvalid_l), .m_ready(m_ready),
        .m_last(mlast_l)
    );

    // RAM port b models: two-stage (latch + output register) and single-stage.
    always @(posedge clk) begin
        if (enb_h) lat_h <= mem[addrb_h];
        if (regceb_h) dout_h <= lat_h;
        if (enb_l) dout_l <= mem[addrb_l];
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_busy_h"}, 32'(busy_h), 0);     chk({tag, "_busy_l"}, 32'(busy_l), 0);
        chk({tag, "_done_h"}, 32'(done_h), 0);     chk({tag, "_done_l"}, 32'(done_l), 0);
        chk({tag, "_enb_h"}, 32'(enb_h), 0);       chk({tag, "_enb_l"}, 32'(enb_l), 0);
        chk({tag, "_regceb_h"}, 32'(regceb_h), 0); chk({tag, "_regceb_l"}, 32'(regceb_l), 0);
        chk({tag, "_addrb_h"}, 32'(addrb_h), 0);   chk({tag, "_addrb_l"}, 32'(addrb_l), 0);
        chk({tag, "_valid_h"}, 32'(mvalid_h), 0);  chk({tag, "_valid_l"}, 32'(mvalid_l), 0);
        chk({tag, "_last_h"}, 32'(mlast_h), 0);    chk({tag, "_last_l"}, 32'(mlast_l), 0);
        chk({tag, "_data_h"}, 32'(mdata_h), 0);    chk({tag, "_data_l"}, 32'(mdata_l), 0);
    endtask

    // One burst on both readers. With rnd=0, m_ready stays 1 and exact cycle timing is checked.
    task automatic burst(input int base, input int n, input bit rnd, input bit poke);
        int iss[2], got[2], first_v[2], done_c[2];
        logic stall_p[2];
        logic [W-1:0] data_p[2];
        for (int d = 0; d < 2; d++) begin
            iss[d] = 0; got[d] = 0; first_v[d] = -1; done_c[d] = -1; stall_p[d] = 1'b0;
            data_p[d] = '0;
        end
        @(negedge clk);
        start = 1'b1; base_addr = 10'(base); nent = 5'(n);
        m_ready = rnd ? 1'($urandom % 2) : 1'b1;
        #1;
        chk("c0_busy_h", 32'(busy_h), 0); chk("c0_busy_l", 32'(busy_l), 0);
        for (int cyc = 1; cyc < 400 && (done_c[0] < 0 || done_c[1] < 0); cyc++) begin
            @(negedge clk);
            start = poke && (cyc == 3);
            base_addr = 10'($urandom % DEPTH);
            nent = 5'($urandom_range(1, 31));
            m_ready = rnd ? 1'($urandom % 2) : 1'b1;
            #1;
            for (int d = 0; d < 2; d++) begin
                logic b, dn, e, v, la;
                logic [9:0] a;
                logic [W-1:0] md;
                int lat;
                if (d == 0) begin
                    b = busy_h; dn = done_h; e = enb_h; v = mvalid_h; la = mlast_h;
                    a = addrb_h; md = mdata_h; lat = 2;
                end else begin
                    b = busy_l; dn = done_l; e = enb_l; v = mvalid_l; la = mlast_l;
                    a = addrb_l; md = mdata_l; lat = 1;
                    chk("regceb_ll", 32'(regceb_l), 0);
                end
                if (done_c[d] < 0) begin
                    if (e) begin
                        chk("enb_addr", 32'(a), 32'((base + iss[d]) % DEPTH));
                        iss[d]++;
                        chk("enb_count_ok", 32'(iss[d] <= n), 1);
                        chk("no_overflow", 32'(iss[d] - got[d] <= FD), 1);
                    end
                    if (stall_p[d]) begin
                        chk("stall_valid", 32'(v), 1);
                        chk("stall_data", 32'(md), 32'(data_p[d]));
                    end
                    if (v && first_v[d] < 0) first_v[d] = cyc;
                    if (v && m_ready) begin
                        chk("data", 32'(md), 32'(mem[(base + got[d]) % DEPTH]));
                        chk("last", 32'(la), 32'(got[d] == n - 1));
                        if (!rnd) chk("hs_cycle", cyc, lat + 2 + got[d]);
                        got[d]++;
                    end
                    stall_p[d] = v && !m_ready;
                    data_p[d] = md;
                    if (dn) begin
                        done_c[d] = cyc;
                        chk("busy_at_done", 32'(b), 0);
                        chk("words_at_done", got[d], n);
                        chk("issues_at_done", iss[d], n);
                    end else begin
                        chk("busy", 32'(b), 32'(n != 0));
                    end
                end
            end
        end
        for (int d = 0; d < 2; d++) begin
            int lat;
            lat = (d == 0) ? 2 : 1;
            chk("done_seen", 32'(done_c[d] >= 0), 1);
            if (!rnd) begin
                chk("done_cycle", done_c[d], (n == 0) ? 1 : lat + n + 2);
                chk("first_valid", first_v[d], (n == 0) ? -1 : lat + 2);
            end
        end
    endtask

    initial begin
        int ndone;
        for (int i = 0; i < DEPTH; i++) mem[i] = W'(i + 'h100);
        rst = 1'b1; start = 1'b0; base_addr = '0; nent = '0; m_ready = 1'b0;
        #3;
        chk_all_zero("reset");
        repeat (2) @(negedge clk);
        rst = 1'b0;

        burst(5, 4, 0, 0);
        burst(1022, 4, 0, 0);
        burst(0, 0, 0, 0);
        burst(int'($urandom % DEPTH), 31, 1, 0);
        burst(0, 2, 0, 0);
        burst(100, 20, 0, 1);
        for (int k = 0; k < 4; k++) begin
            burst(int'($urandom % DEPTH), int'($urandom_range(1, 31)), 1, 0);
        end

        // Abort a burst while two words sit in the FIFO and the reader is draining.
        @(negedge clk);
        start = 1'b1; base_addr = 10'h040; nent = 5'd2; m_ready = 1'b0;
        @(negedge clk);
        start = 1'b0;
        repeat (5) @(negedge clk);
        #1;
        chk("pre_reset_valid_h", 32'(mvalid_h), 1);
        chk("pre_reset_busy_h", 32'(busy_h), 1);
        rst = 1'b1;
        #1;
        chk_all_zero("midreset");
        m_ready = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        ndone = 0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            #1;
            if (done_h || done_l || mvalid_h || mvalid_l) ndone++;
        end
        chk("no_done_after_abort", ndone, 0);
        burst(0, 1, 0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
